// File: rtl/alarm_sched.sv
// Alarm sequencer: arm, hour/minute match, ring, snooze with limit, ring timeout.
// Define ALARM_BEEP_EN for a pulsed (1,0,1,0...) buzz while ringing.
module alarm_sched #(
  parameter int SNOOZE_SEC = 540,
  parameter int RING_SEC   = 120,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] tsec,
  input  logic [6:0] tmin,
  input  logic [6:0] thrs,
  input  logic [6:0] amin,
  input  logic [6:0] ahrs,
  input  logic       alarmon,
  input  logic       timeset,
  input  logic       snooze,
  output logic       buzz,
  output logic [1:0] state,
  output logic [3:0] snooze_used
);

  localparam int MAXC = (SNOOZE_SEC > RING_SEC) ? SNOOZE_SEC : RING_SEC;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] RING_LAST = CW'(RING_SEC - 1);
  localparam logic [CW-1:0] SNZ_LOAD  = CW'(SNOOZE_SEC - 1);
  localparam logic [3:0]    SNZ_MAX   = 4'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] ring_q, ring_d;
  logic [CW-1:0] snz_q, snz_d;
  logic [3:0]    used_q, used_d;
  logic          buzz_q, buzz_d;
  logic          match;

  assign match = (thrs == ahrs) && (tmin == amin) &&
                 (tsec == 7'd0) && !timeset;

  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
    snz_d   = snz_q;
    used_d  = used_q;
    unique case (state_q)
      IDLE: begin
        used_d = '0;
        if (alarmon) state_d = ARMED;
      end
      ARMED: begin
        if (!alarmon) begin
          state_d = IDLE;
        end else if (match) begin
          state_d = RINGING;
          ring_d  = '0;
        end
      end
      RINGING: begin
        if (!alarmon) begin
          state_d = IDLE;
          used_d  = '0;
        end else if (snooze && (used_q < SNZ_MAX)) begin
          state_d = SNOOZE;
          snz_d   = SNZ_LOAD;
          used_d  = used_q + 4'd1;
        end else if (ring_q == RING_LAST) begin
          state_d = ARMED;
          used_d  = '0;
        end else begin
          ring_d = ring_q + 1'b1;
        end
      end
      SNOOZE: begin
        if (!alarmon) begin
          state_d = IDLE;
          used_d  = '0;
        end else if (snz_q == '0) begin
          state_d = RINGING;
          ring_d  = '0;
        end else begin
          snz_d = snz_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // buzz is registered alongside state so it is a clean Moore output
  always_comb begin
    buzz_d = 1'b0;
`ifdef ALARM_BEEP_EN
    if (state_d == RINGING)
      buzz_d = (state_q != RINGING) || !buzz_q;
`else
    buzz_d = (state_d == RINGING);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ring_q  <= '0;
      snz_q   <= '0;
      used_q  <= '0;
      buzz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ring_q  <= ring_d;
      snz_q   <= snz_d;
      used_q  <= used_d;
      buzz_q  <= buzz_d;
    end
  end

  assign state       = state_q;
  assign buzz        = buzz_q;
  assign snooze_used = used_q;

endmodule

// File: tb/tb_alarm_sched.sv
// Scoreboard bench for alarm_sched: timestamp-based reference model
// feeds an expected-output queue, a negedge monitor pops and compares.
module tb_alarm_sched;

  localparam int SNZ  = 5;
  localparam int RING = 8;
  localparam int MAXS = 2;

  logic       clk;
  logic       rst;
  logic [6:0] tsec, tmin, thrs, amin, ahrs;
  logic       alarmon, timeset, snooze;
  logic       buzz;
  logic [1:0] state;
  logic [3:0] snooze_used;

  alarm_sched #(
    .SNOOZE_SEC(SNZ),
    .RING_SEC  (RING),
    .MAX_SNOOZE(MAXS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tsec       (tsec),
    .tmin       (tmin),
    .thrs       (thrs),
    .amin       (amin),
    .ahrs       (ahrs),
    .alarmon    (alarmon),
    .timeset    (timeset),
    .snooze     (snooze),
    .buzz       (buzz),
    .state      (state),
    .snooze_used(snooze_used)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int st;
    int bz;
    int su;
    int k;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // model: state code, snoozes used, edge at which current state was entered
  int ms  = 0;
  int mu  = 0;
  int ment = 0;
  int kk  = 0;

  task automatic tick();
    exp_t e;
    bit   m;
    int   age;
    m = (thrs == ahrs) && (tmin == amin) && (tsec == 7'd0) && !timeset;
    kk++;
    age = kk - ment;
    if (rst) begin
      ms = 0; mu = 0; ment = kk;
    end else begin
      case (ms)
        0: if (alarmon) begin ms = 1; ment = kk; end
        1: if (!alarmon) begin ms = 0; ment = kk; end
           else if (m) begin ms = 2; ment = kk; end
        2: if (!alarmon) begin ms = 0; mu = 0; ment = kk; end
           else if (snooze && mu < MAXS) begin ms = 3; mu++; ment = kk; end
           else if (age == RING) begin ms = 1; mu = 0; ment = kk; end
        default: if (!alarmon) begin ms = 0; mu = 0; ment = kk; end
           else if (age == SNZ) begin ms = 2; ment = kk; end
      endcase
    end
    e.st = ms;
    e.su = mu;
    e.k  = kk;
`ifdef ALARM_BEEP_EN
    e.bz = (ms == 2 && ((kk - ment) % 2) == 0) ? 1 : 0;
`else
    e.bz = (ms == 2) ? 1 : 0;
`endif
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic chk(string nm, int got, int exp, int k);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL edge%0d %s got %0d expected %0d", k, nm, got, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("state", int'(state), e.st, e.k);
        chk("buzz", int'(buzz), e.bz, e.k);
        chk("snooze_used", int'(snooze_used), e.su, e.k);
      end
    end
  end

  task automatic hit();
    thrs = ahrs; tmin = amin; tsec = 7'd0;
  endtask

  initial begin
    rst = 1'b1; alarmon = 1'b1; timeset = 1'b0; snooze = 1'b0;
    ahrs = 7'd7; amin = 7'd30;
    thrs = 7'd6; tmin = 7'd0; tsec = 7'd0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    // match, then the rest of that minute must not retrigger
    hit(); tick();
    for (int s = 1; s < 60; s++) begin tsec = 7'(s); tick(); end
    // snooze twice, third snooze ignored, then timeout
    hit(); tick();
    tsec = 7'd1;
    for (int n = 0; n < 3; n++) begin
      snooze = 1'b1; tick();
      snooze = 1'b0; repeat (SNZ + 1) tick();
    end
    repeat (RING + 2) tick();
    // timeset and alarmon gate the match
    timeset = 1'b1; hit(); repeat (2) tick();
    timeset = 1'b0; alarmon = 1'b0; tick(); hit(); repeat (2) tick();
    alarmon = 1'b1; tsec = 7'd5; repeat (2) tick();
    // alarm off while ringing, while snoozing; reset mid-snooze
    hit(); tick(); tsec = 7'd1; repeat (2) tick();
    alarmon = 1'b0; tick(); alarmon = 1'b1; repeat (2) tick();
    hit(); tick(); tsec = 7'd1; snooze = 1'b1; tick(); snooze = 1'b0;
    repeat (2) tick(); alarmon = 1'b0; tick(); alarmon = 1'b1; repeat (2) tick();
    hit(); tick(); tsec = 7'd1; snooze = 1'b1; tick(); snooze = 1'b0;
    tick(); rst = 1'b1; tick(); rst = 1'b0; repeat (2) tick();
    // snooze on the last ring cycle wins over timeout
    hit(); tick(); tsec = 7'd1;
    repeat (RING - 1) tick();
    snooze = 1'b1; tick(); snooze = 1'b0;
    repeat (SNZ + RING + 2) tick();
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 149) == 0);
      timeset = ($urandom_range(0, 9) == 0);
      snooze  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 39) == 0) alarmon = ~alarmon;
      if ($urandom_range(0, 199) == 0) begin
        ahrs = 7'($urandom_range(0, 23));
        amin = 7'($urandom_range(0, 59));
      end
      if ($urandom_range(0, 14) == 0) begin
        hit();
      end else begin
        thrs = ($urandom_range(0, 1) == 0) ? ahrs : 7'($urandom_range(0, 23));
        tmin = ($urandom_range(0, 1) == 0) ? amin : 7'($urandom_range(0, 59));
        tsec = 7'($urandom_range(0, 59));
      end
      tick();
    end
    rst = 1'b0; snooze = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain queue left %0d expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
